// File: rtl/set_scan_pkg.sv
// Shared types, mode encodings and the membership predicate for the
// lattice-point set-scan engine.
package set_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] MODE_A      = 3'd0;
    localparam logic [2:0] MODE_AND_AB = 3'd1;
    localparam logic [2:0] MODE_XOR_AB = 3'd2;
    localparam logic [2:0] MODE_TWO    = 3'd3;
    localparam logic [2:0] MODE_ANY    = 3'd4;
    localparam logic [2:0] MODE_ALL    = 3'd5;
    localparam logic [2:0] MODE_ONE    = 3'd6;
    localparam logic [2:0] MODE_NONE   = 3'd7;

    function automatic logic predicate(input logic [2:0] mode,
                                       input logic       m_a,
                                       input logic       m_b,
                                       input logic       m_c);
        logic [1:0] hits;
        logic       sel;
        hits = {1'b0, m_a} + {1'b0, m_b} + {1'b0, m_c};
        case (mode)
            MODE_A:      sel = m_a;
            MODE_AND_AB: sel = m_a & m_b;
            MODE_XOR_AB: sel = m_a ^ m_b;
            MODE_TWO:    sel = (hits == 2'd2);
            MODE_ANY:    sel = (hits != 2'd0);
            MODE_ALL:    sel = (hits == 2'd3);
            MODE_ONE:    sel = (hits == 2'd1);
            default:     sel = (hits == 2'd0);
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/set_member_pipe.sv
// One circle's membership pipeline: S1 registers signed offsets, S2 registers
// whether the point lies within the radius.
module set_member_pipe #(
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] xc,
    input  logic [COORD_W-1:0] yc,
    input  logic [COORD_W-1:0] r,
    output logic               member
);

    localparam int DW = COORD_W + 1;
    localparam int SW = 2 * COORD_W + 3;

    logic signed [DW-1:0] dx_d, dx_q, dy_d, dy_q;
    logic signed [SW-1:0] dx_ext, dy_ext;
    logic        [SW-1:0] dist_sq, r_ext, r_sq;
    logic                 m_d, m_q;

    always_comb begin
        dx_d = $signed({1'b0, x}) - $signed({1'b0, xc});
        dy_d = $signed({1'b0, y}) - $signed({1'b0, yc});
    end

    // Sum of squares kept at full width so large radii never alias.
    always_comb begin
        dx_ext  = {{(SW-DW){dx_q[DW-1]}}, dx_q};
        dy_ext  = {{(SW-DW){dy_q[DW-1]}}, dy_q};
        dist_sq = dx_ext * dx_ext + dy_ext * dy_ext;
        r_ext   = {{(SW-COORD_W){1'b0}}, r};
        r_sq    = r_ext * r_ext;
        m_d     = (dist_sq <= r_sq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
            m_q  <= 1'b0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            m_q  <= m_d;
        end
    end

    assign member = m_q;

endmodule

// File: rtl/set_scan_engine.sv
// Scans a GRID x GRID lattice one point per clock and counts the points that
// satisfy the selected Boolean combination of three circle memberships.
module set_scan_engine
    import set_scan_pkg::*;
#(
    parameter int GRID    = 8,
    parameter int COORD_W = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [6*COORD_W-1:0] central,
    input  logic [3*COORD_W-1:0] radius,
    input  logic [2:0]           mode,
    output logic                 busy,
    output logic                 valid,
    output logic [CNT_W-1:0]     candidate
);

    localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);
    localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

    state_t               state_d, state_q;
    logic [COORD_W-1:0]   x_d, x_q, y_d, y_q;
    logic                 drain_d, drain_q;
    logic [6*COORD_W-1:0] cen_d, cen_q;
    logic [3*COORD_W-1:0] rad_d, rad_q;
    logic [2:0]           mode_d, mode_q;
    logic                 v1_d, v1_q, v2_d, v2_q;
    logic [CNT_W-1:0]     acc_d, acc_q, cand_d, cand_q;
    logic                 m_a, m_b, m_c;

    set_member_pipe #(.COORD_W(COORD_W)) u_pipe_a (
        .clk(clk), .rst(rst), .x(x_q), .y(y_q),
        .xc(cen_q[6*COORD_W-1 -: COORD_W]), .yc(cen_q[5*COORD_W-1 -: COORD_W]),
        .r(rad_q[3*COORD_W-1 -: COORD_W]), .member(m_a)
    );

    set_member_pipe #(.COORD_W(COORD_W)) u_pipe_b (
        .clk(clk), .rst(rst), .x(x_q), .y(y_q),
        .xc(cen_q[4*COORD_W-1 -: COORD_W]), .yc(cen_q[3*COORD_W-1 -: COORD_W]),
        .r(rad_q[2*COORD_W-1 -: COORD_W]), .member(m_b)
    );

    set_member_pipe #(.COORD_W(COORD_W)) u_pipe_c (
        .clk(clk), .rst(rst), .x(x_q), .y(y_q),
        .xc(cen_q[2*COORD_W-1 -: COORD_W]), .yc(cen_q[COORD_W-1 -: COORD_W]),
        .r(rad_q[COORD_W-1 -: COORD_W]), .member(m_c)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        drain_d = drain_q;
        cen_d   = cen_q;
        rad_d   = rad_q;
        mode_d  = mode_q;
        v1_d    = (state_q == SCAN);
        v2_d    = v1_q;
        acc_d   = acc_q;
        cand_d  = cand_q;

        if (v2_q && predicate(mode_q, m_a, m_b, m_c)) begin
            acc_d = acc_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SCAN;
                    cen_d   = central;
                    rad_d   = radius;
                    mode_d  = mode;
                    acc_d   = '0;
                    x_d     = ONE_C;
                    y_d     = ONE_C;
                end
            end
            SCAN: begin
                if (x_q == GRID_C) begin
                    x_d = ONE_C;
                    if (y_q == GRID_C) begin
                        y_d     = ONE_C;
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        y_d = y_q + ONE_C;
                    end
                end else begin
                    x_d = x_q + ONE_C;
                end
            end
            DRAIN: begin
                // The last point's increment lands on this same edge, so latch acc_d.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                    cand_d  = acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= ONE_C;
            y_q     <= ONE_C;
            drain_q <= 1'b0;
            cen_q   <= '0;
            rad_q   <= '0;
            mode_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drain_q <= drain_d;
            cen_q   <= cen_d;
            rad_q   <= rad_d;
            mode_q  <= mode_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            acc_q   <= acc_d;
            cand_q  <= cand_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign valid     = (state_q == DONE);
    assign candidate = cand_q;

endmodule

// File: tb/tb_set_scan_engine.sv
// Scoreboard bench for set_scan_engine: expected counts are queued at command
// issue and compared when valid pulses.
module tb_set_scan_engine;

    localparam int GRID    = 8;
    localparam int COORD_W = 4;
    localparam int CNT_W   = 8;
    localparam int N       = GRID * GRID;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [2:0]       mode;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] candidate;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int last_exp = 0;

    set_scan_engine #(.GRID(GRID), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input logic [3:0] xa, input logic [3:0] ya,
                                       input logic [3:0] xb, input logic [3:0] yb,
                                       input logic [3:0] xc, input logic [3:0] yc);
        return {xa, ya, xb, yb, xc, yc};
    endfunction

    function automatic int inside_c(input int x, input int y, input logic [3:0] cx,
                                    input logic [3:0] cy, input logic [3:0] r);
        int dx, dy, rr;
        dx = x - int'(cx);
        dy = y - int'(cy);
        rr = int'(r);
        return (dx * dx + dy * dy <= rr * rr) ? 1 : 0;
    endfunction

    function automatic int model(input logic [23:0] c, input logic [11:0] r,
                                 input logic [2:0] m);
        int cnt, a, b, cc, hits, hit;
        cnt = 0;
        for (int y = 1; y <= GRID; y++) begin
            for (int x = 1; x <= GRID; x++) begin
                a    = inside_c(x, y, c[23:20], c[19:16], r[11:8]);
                b    = inside_c(x, y, c[15:12], c[11:8], r[7:4]);
                cc   = inside_c(x, y, c[7:4], c[3:0], r[3:0]);
                hits = a + b + cc;
                case (m)
                    3'd0: hit = a;
                    3'd1: hit = a & b;
                    3'd2: hit = a ^ b;
                    3'd3: hit = (hits == 2) ? 1 : 0;
                    3'd4: hit = (hits > 0) ? 1 : 0;
                    3'd5: hit = (hits == 3) ? 1 : 0;
                    3'd6: hit = (hits == 1) ? 1 : 0;
                    default: hit = (hits == 0) ? 1 : 0;
                endcase
                cnt += hit;
            end
        end
        return cnt;
    endfunction

    // Drives a command in the current cycle (cycle 0) and queues its expectation.
    task automatic start_cmd(input logic [23:0] c, input logic [11:0] r,
                             input logic [2:0] m, input int expected);
        central = c;
        radius  = r;
        mode    = m;
        en      = 1'b1;
        exp_q.push_back(expected);
    endtask

    task automatic await_result(input string name, input int poke_at, input bit keep_en);
        bit   seen;
        bit   busy_bad;
        int   exp_v;
        seen     = 1'b0;
        busy_bad = 1'b0;
        for (int cyc = 1; cyc <= N + 20 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1 && !keep_en) en = 1'b0;
            if (poke_at != 0 && cyc == poke_at) begin
                en      = 1'b1;
                central = pk(4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3);
                radius  = 12'hfff;
                mode    = 3'd7;
            end
            if (poke_at != 0 && cyc == poke_at + 1) en = 1'b0;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (cyc != N + 3) begin
                    $display("FAIL %s valid_cycle actual=%0d required=%0d", name, cyc, N + 3);
                    errors++;
                end
                exp_v    = exp_q.pop_front();
                last_exp = exp_v;
                checks++;
                if (candidate !== CNT_W'(exp_v)) begin
                    $display("FAIL %s candidate actual=%0d required=%0d", name, candidate, exp_v);
                    errors++;
                end
            end
        end
        checks++;
        if (!seen) begin
            $display("FAIL %s timeout actual=no_valid required=valid_at_%0d", name, N + 3);
            errors++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        checks++;
        if (busy_bad) begin
            $display("FAIL %s busy_during_cmd actual=0 required=1", name);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            $display("FAIL %s after_done busy=%b valid=%b required busy=0 valid=0", name, busy, valid);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        central = '0;
        radius  = '0;
        mode    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy actual=%b required=0", busy); errors++; end
        checks++;
        if (valid !== 1'b0) begin $display("FAIL reset_valid actual=%b required=0", valid); errors++; end
        checks++;
        if (candidate !== '0) begin $display("FAIL reset_candidate actual=%0d required=0", candidate); errors++; end
        rst = 1'b0;
    endtask

    task automatic test_single_circle();
        start_cmd(pk(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0), {4'd2, 4'd0, 4'd0}, 3'd0, 13);
        await_result("mode0_r2", 0, 1'b0);
    endtask

    task automatic test_ignored_en();
        start_cmd(pk(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0), {4'd2, 4'd0, 4'd0}, 3'd0, 13);
        await_result("en_ignored", 30, 1'b0);
    endtask

    task automatic test_back_to_back();
        start_cmd(pk(4'd3, 4'd3, 4'd4, 4'd3, 4'd0, 4'd0), {4'd1, 4'd1, 4'd0}, 3'd1, 2);
        await_result("b2b_and", 0, 1'b1);
        start_cmd(pk(4'd3, 4'd3, 4'd4, 4'd3, 4'd0, 4'd0), {4'd1, 4'd1, 4'd0}, 3'd2, 6);
        await_result("b2b_xor", 0, 1'b0);
    endtask

    task automatic test_point_circles();
        logic [23:0] c;
        c = pk(4'd1, 4'd1, 4'd8, 4'd8, 4'd1, 4'd1);
        start_cmd(c, 12'h000, 3'd4, 2);
        await_result("pts_any", 0, 1'b0);
        start_cmd(c, 12'h000, 3'd5, 0);
        await_result("pts_all", 0, 1'b0);
        start_cmd(c, 12'h000, 3'd7, 62);
        await_result("pts_none", 0, 1'b0);
        start_cmd(c, 12'h000, 3'd3, 1);
        await_result("pts_two", 0, 1'b0);
    endtask

    task automatic test_full_width();
        start_cmd(pk(4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0), {4'd8, 4'd0, 4'd0}, 3'd0, 56);
        await_result("wide_r8", 0, 1'b0);
        start_cmd(pk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0), {4'd1, 4'd0, 4'd0}, 3'd0, 0);
        await_result("offgrid", 0, 1'b0);
    endtask

    task automatic test_hold();
        bit bad;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (candidate !== CNT_W'(last_exp)) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            $display("FAIL hold_candidate actual=%0d required=%0d", candidate, last_exp);
            errors++;
        end
    endtask

    task automatic test_reset_mid_scan();
        start_cmd(pk(4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0), {4'd2, 4'd0, 4'd0}, 3'd0, 13);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) en = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || candidate !== '0) begin
            $display("FAIL mid_reset busy=%b valid=%b candidate=%0d required 0/0/0", busy, valid, candidate);
            errors++;
        end
        start_cmd(pk(4'd3, 4'd3, 4'd4, 4'd3, 4'd0, 4'd0), {4'd1, 4'd1, 4'd0}, 3'd2, 6);
        await_result("after_reset", 0, 1'b0);
    endtask

    task automatic test_random();
        logic [23:0] c;
        logic [11:0] r;
        logic [2:0]  m;
        for (int i = 0; i < 4; i++) begin
            c = 24'($urandom);
            r = 12'($urandom_range(0, 12'hfff)) & 12'h777;
            m = 3'($urandom_range(0, 7));
            start_cmd(c, r, m, model(c, r, m));
            await_result("random", 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_circle();
        test_ignored_en();
        test_back_to_back();
        test_hold();
        test_point_circles();
        test_full_width();
        test_reset_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
